// File: rtl/adder_axi_master.sv
// AXI4-Lite master that sequences the adder peripheral: write r0, r1, ctrl, poll status, read r2.
// Optional poll timeout enabled by ADDER_AXI_MASTER_POLL_TIMEOUT_EN.
//
// state       | meaning
// S_IDLE      | waiting for a job, o_ready=1
// S_WADDR     | AW and W offered, each dropped on its own handshake
// S_WRESP     | waiting for B
// S_POLL_WAIT | idle gap before the next status read
// S_RADDR     | AR offered
// S_RDATA     | waiting for R
// S_OUT       | result offered on o_valid
module adder_axi_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int POLL_GAP = 2,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [31:0]                       i_op0,
  input  logic [31:0]                       i_op1,
  input  logic                              i_op,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [31:0]                       o_result,
  output logic                              o_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] ADDR_R0   = BASE_ADDR;
  localparam logic [AW-1:0] ADDR_R1   = BASE_ADDR + AW'(4);
  localparam logic [AW-1:0] ADDR_R2   = BASE_ADDR + AW'(8);
  localparam logic [AW-1:0] ADDR_CTRL = BASE_ADDR + AW'(12);

  if (DW != 32) begin : g_dw_check
    $error("adder_axi_master supports only a 32-bit data bus");
  end
  if (POLL_LIMIT < 1) begin : g_limit_check
    $error("adder_axi_master POLL_LIMIT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_POLL_WAIT, S_RADDR, S_RDATA, S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   op0_q, op0_d, op1_q, op1_d;
  logic          op_q, op_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_status_q, rd_status_d;
  logic [15:0]   gap_q, gap_d;
  logic [31:0]   result_q, result_d;
  logic          err_q, err_d;
  logic          enter_poll;
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
  logic [31:0]   poll_q, poll_d;
`endif

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      op_q        <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rd_status_q <= 1'b0;
      gap_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
      poll_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      op_q        <= op_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      rd_status_q <= rd_status_d;
      gap_q       <= gap_d;
      result_q    <= result_d;
      err_q       <= err_d;
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
      poll_q      <= poll_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    op_d        = op_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rd_status_d = rd_status_q;
    gap_d       = gap_q;
    result_d    = result_q;
    err_d       = err_q;
    enter_poll  = 1'b0;
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
    poll_d      = poll_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op0_d     = i_op0;
          op1_d     = i_op1;
          op_d      = i_op;
          idx_d     = 2'd0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_R0;
          wdata_d   = DW'(i_op0);
          err_d     = 1'b0;
          result_d  = '0;
          state_d   = S_WADDR;
        end
      end
      S_WADDR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_OUT;
          end else if (idx_q != 2'd2) begin
            idx_d     = idx_q + 2'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            if (idx_q == 2'd0) begin
              awaddr_d = ADDR_R1;
              wdata_d  = DW'(op1_q);
            end else begin
              awaddr_d = ADDR_CTRL;
              wdata_d  = DW'({30'b0, op_q, 1'b1});
            end
            state_d = S_WADDR;
          end else begin
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
            poll_d = '0;
`endif
            enter_poll = 1'b1;
          end
        end
      end
      S_POLL_WAIT: begin
        if (gap_q == '0) begin
          arvalid_d   = 1'b1;
          araddr_d    = ADDR_CTRL;
          rd_status_d = 1'b1;
          state_d     = S_RADDR;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_OUT;
          end else if (rd_status_q) begin
            if (M_AXI_RDATA[DW-1]) begin
              arvalid_d   = 1'b1;
              araddr_d    = ADDR_R2;
              rd_status_d = 1'b0;
              state_d     = S_RADDR;
            end else begin
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
              if (poll_q == 32'(POLL_LIMIT - 1)) begin
                err_d    = 1'b1;
                result_d = '0;
                state_d  = S_OUT;
              end else begin
                poll_d     = poll_q + 32'd1;
                enter_poll = 1'b1;
              end
`else
              enter_poll = 1'b1;
`endif
            end
          end else begin
            result_d = 32'(M_AXI_RDATA);
            state_d  = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A zero gap skips POLL_WAIT entirely so the status read follows immediately.
    if (enter_poll) begin
      if (POLL_GAP == 0) begin
        arvalid_d   = 1'b1;
        araddr_d    = ADDR_CTRL;
        rd_status_d = 1'b1;
        state_d     = S_RADDR;
      end else begin
        gap_d   = 16'(POLL_GAP - 1);
        state_d = S_POLL_WAIT;
      end
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_valid       = (state_q == S_OUT);
  assign o_result      = result_q;
  assign o_err         = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {(DW/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_adder_axi_master.sv
// Directed bench for adder_axi_master against a small AXI4-Lite adder slave model.
// Expectations follow ADDER_AXI_MASTER_POLL_TIMEOUT_EN when it is defined.
module tb_adder_axi_master;
  localparam logic [31:0] A_R0 = 32'h0, A_R1 = 32'h4, A_R2 = 32'h8, A_CTRL = 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        i_valid = 1'b0, i_op = 1'b0, i_ready = 1'b0;
  logic [31:0] i_op0 = '0, i_op1 = '0;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_result;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  adder_axi_master #(.POLL_GAP(2), .POLL_LIMIT(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_op0(i_op0), .i_op1(i_op1), .i_op(i_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_err(o_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_tests = 0, n_fail = 0;

  // slave configuration, changed only while the master is idle
  int          aw_delay = 0, w_delay = 0, done_after = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        clr = 1'b1;

  int          aw_cnt, w_cnt, job_polls;
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [1:0]  bresp_r;
  logic [31:0] aw_addr_l, w_data_l, rdata_r, r0_s, r1_s, ctrl_s;
  int          wr_count, ctrl_writes, aw_hs, w_hs, ar_count, status_reads, result_reads;
  int          violations, ar_low, min_gap;
  logic        ar_seen;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [31:0] wlog_addr [0:7];
  logic [31:0] wlog_data [0:7];

  logic        aw_fire, w_fire, ar_fire, wr_complete;
  logic [31:0] wr_addr_cur, wr_data_cur, result_s;

  assign M_AXI_AWREADY = (aw_cnt >= aw_delay) && !aw_got;
  assign M_AXI_WREADY  = (w_cnt >= w_delay) && !w_got;
  assign M_AXI_ARREADY = 1'b1;
  assign M_AXI_BVALID  = bvalid_r;
  assign M_AXI_BRESP   = bresp_r;
  assign M_AXI_RVALID  = rvalid_r;
  assign M_AXI_RDATA   = rdata_r;
  assign M_AXI_RRESP   = 2'b00;
  assign aw_fire       = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire        = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_fire       = M_AXI_ARVALID && M_AXI_ARREADY;
  assign wr_complete   = (aw_got || aw_fire) && (w_got || w_fire) && !bvalid_r;
  assign wr_addr_cur   = aw_got ? aw_addr_l : M_AXI_AWADDR;
  assign wr_data_cur   = w_got ? w_data_l : M_AXI_WDATA;
  assign result_s      = ctrl_s[1] ? (r0_s + r1_s) : (r0_s - r1_s);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_r <= 1'b0; bresp_r <= 2'b00; rvalid_r <= 1'b0; rdata_r <= '0;
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0;
    end else begin
      p_awv <= M_AXI_AWVALID; p_awr <= M_AXI_AWREADY; p_awaddr <= M_AXI_AWADDR;
      p_wv <= M_AXI_WVALID; p_wr <= M_AXI_WREADY; p_wdata <= M_AXI_WDATA;
      p_arv <= M_AXI_ARVALID; p_arr <= M_AXI_ARREADY; p_araddr <= M_AXI_ARADDR;
      if (clr) begin
        aw_cnt <= 0; w_cnt <= 0; job_polls <= 0;
        wr_count <= 0; ctrl_writes <= 0; aw_hs <= 0; w_hs <= 0; ar_count <= 0;
        status_reads <= 0; result_reads <= 0; violations <= 0;
        ar_low <= 0; min_gap <= 1000; ar_seen <= 1'b0;
      end else begin
        if (aw_fire) begin aw_cnt <= 0; aw_hs <= aw_hs + 1; end
        else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
        if (w_fire) begin w_cnt <= 0; w_hs <= w_hs + 1; end
        else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;

        if (wr_complete) begin
          aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b1;
          bresp_r <= (wr_addr_cur == err_addr) ? 2'b10 : 2'b00;
          wr_count <= wr_count + 1;
          if (wr_count < 8) begin
            wlog_addr[wr_count[2:0]] <= wr_addr_cur;
            wlog_data[wr_count[2:0]] <= wr_data_cur;
          end
          if (wr_addr_cur != err_addr) begin
            if (wr_addr_cur == A_R0) r0_s <= wr_data_cur;
            if (wr_addr_cur == A_R1) r1_s <= wr_data_cur;
            if (wr_addr_cur == A_CTRL) begin
              ctrl_s <= wr_data_cur; ctrl_writes <= ctrl_writes + 1; job_polls <= 0;
            end
          end
        end else begin
          if (aw_fire) begin aw_got <= 1'b1; aw_addr_l <= M_AXI_AWADDR; end
          if (w_fire) begin w_got <= 1'b1; w_data_l <= M_AXI_WDATA; end
          if (bvalid_r && M_AXI_BREADY) bvalid_r <= 1'b0;
        end

        if (ar_fire) begin
          ar_count <= ar_count + 1; rvalid_r <= 1'b1;
          if (M_AXI_ARADDR == A_CTRL) begin
            status_reads <= status_reads + 1;
            job_polls <= job_polls + 1;
            rdata_r <= (job_polls + 1 >= done_after) ? 32'h8000_0000 : 32'h0;
          end else if (M_AXI_ARADDR == A_R2) begin
            result_reads <= result_reads + 1;
            rdata_r <= result_s;
          end else rdata_r <= '0;
        end else if (rvalid_r && M_AXI_RREADY) rvalid_r <= 1'b0;

        // idle cycles before each status-read AR
        if (M_AXI_ARVALID && !p_arv && ar_seen && M_AXI_ARADDR == A_CTRL && ar_low < min_gap)
          min_gap <= ar_low;
        if (M_AXI_ARVALID) begin ar_low <= 0; ar_seen <= 1'b1; end
        else ar_low <= ar_low + 1;

        if (((M_AXI_ARVALID || M_AXI_RREADY) && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)) ||
            (p_awv && !p_awr && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) ||
            (p_wv && !p_wr && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata)) ||
            (p_arv && !p_arr && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)))
          violations <= violations + 1;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    i_op0 = a; i_op1 = b; i_op = op; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [31:0] res, output logic err);
    int n = 0;
    @(negedge clk);
    while (!o_valid && n < 2000) begin @(negedge clk); n++; end
    chk_eq("o_valid_seen", o_valid, 1'b1);
    res = o_result; err = o_err;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk_eq("ready_after_out", o_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] res;
    logic        err;
    int          n;

    #1 rst = 1'b1;
    #2;
    chk_eq("rst_o_ready", o_ready, 1'b1);
    chk_eq("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, o_valid}, 0);
    chk_eq("rst_awaddr", M_AXI_AWADDR, 0);
    chk_eq("rst_araddr", M_AXI_ARADDR, 0);
    chk_eq("rst_wdata", M_AXI_WDATA, 0);
    chk_eq("rst_result_err", {o_result[30:0], o_err}, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // sub 2-1, zero-wait slave
    start_job(32'd2, 32'd1, 1'b0);
    chk_eq("accept_awvalid_wvalid", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    chk_eq("accept_o_ready", o_ready, 1'b0);
    chk_eq("accept_awaddr", M_AXI_AWADDR, A_R0);
    chk_eq("accept_wdata", M_AXI_WDATA, 32'd2);
    chk_eq("prot_strb", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, 10'h00F);
    wait_out(res, err);
    chk_eq("sub_result", res, 32'd1);
    chk_eq("sub_err", err, 1'b0);
    chk_eq("sub_wr_count", wr_count, 3);
    chk_eq("sub_w0", {wlog_addr[0][7:0], wlog_data[0][7:0]}, 16'h0002);
    chk_eq("sub_w1", {wlog_addr[1][7:0], wlog_data[1][7:0]}, 16'h0401);
    chk_eq("sub_w2", {wlog_addr[2][7:0], wlog_data[2][7:0]}, 16'h0C01);
    chk_eq("sub_reads", {status_reads[7:0], result_reads[7:0]}, 16'h0101);
    chk_eq("sub_violations", violations, 0);
    @(negedge clk);
    chk_eq("result_hold", o_result, 32'd1);

    // add 5+7 with AWREADY 3 cycles late
    aw_delay = 3;
    start_job(32'd5, 32'd7, 1'b1);
    wait_out(res, err);
    aw_delay = 0;
    chk_eq("add_bp_result", res, 32'd12);
    chk_eq("add_bp_aw_w_hs", {aw_hs[7:0], w_hs[7:0]}, 16'h0303);
    chk_eq("add_bp_ctrl", {wlog_addr[2][7:0], wlog_data[2][7:0]}, 16'h0C03);
    chk_eq("add_bp_violations", violations, 0);

    // sub 10-3 with WREADY 3 cycles late
    w_delay = 3;
    start_job(32'd10, 32'd3, 1'b0);
    wait_out(res, err);
    w_delay = 0;
    chk_eq("sub_wbp_result", res, 32'd7);
    chk_eq("sub_wbp_aw_w_hs", {aw_hs[7:0], w_hs[7:0]}, 16'h0303);
    chk_eq("sub_wbp_violations", violations, 0);

    // done only on the 4th poll
    done_after = 4;
    start_job(32'd100, 32'd58, 1'b1);
    wait_out(res, err);
    done_after = 1;
    chk_eq("slow_result", res, 32'd158);
    chk_eq("slow_status_reads", status_reads, 4);
    chk_eq("slow_result_reads", result_reads, 1);
    chk_eq("slow_poll_gap_ge2", (min_gap >= 2), 1'b1);
    chk_eq("slow_violations", violations, 0);

    // SLVERR on the r1 write
    err_addr = A_R1;
    start_job(32'd4, 32'd4, 1'b1);
    wait_out(res, err);
    err_addr = 32'hFFFF_FFFF;
    chk_eq("berr_err", err, 1'b1);
    chk_eq("berr_wr_count", wr_count, 2);
    chk_eq("berr_ctrl_writes", ctrl_writes, 0);
    chk_eq("berr_ar_count", ar_count, 0);

    // done never set
    done_after = 1000;
    start_job(32'd1, 32'd1, 1'b1);
`ifdef ADDER_AXI_MASTER_POLL_TIMEOUT_EN
    wait_out(res, err);
    chk_eq("timeout_err", err, 1'b1);
    chk_eq("timeout_result", res, 32'd0);
    chk_eq("timeout_status_reads", status_reads, 8);
    chk_eq("timeout_result_reads", result_reads, 0);
`else
    n = 0;
    while (status_reads < 12 && n < 1000) begin @(negedge clk); n++; end
    chk_eq("poll_past_limit", (status_reads > 8), 1'b1);
    chk_eq("no_out_while_polling", o_valid, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`endif
    done_after = 1;

    // reset while AWVALID is held by a stalled slave
    aw_delay = 20;
    start_job(32'd7, 32'd9, 1'b1);
    chk_eq("pre_reset_awvalid", M_AXI_AWVALID, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_eq("reset_awvalid_drop", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b00);
    chk_eq("reset_o_ready", o_ready, 1'b1);
    @(negedge clk); rst = 1'b0;
    aw_delay = 0;
    start_job(32'd7, 32'd9, 1'b1);
    wait_out(res, err);
    chk_eq("post_reset_result", res, 32'd16);
    chk_eq("post_reset_err", err, 1'b0);
    chk_eq("post_reset_wr_count", wr_count, 3);
    chk_eq("post_reset_violations", violations, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
